// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 single-bit mux.
// Grants are held until the owner drops its request or HOLD_MAX expires.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic [3:0] i_data,
  output logic [3:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_valid,
  output logic       o_out,
  output logic       o_timeout
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  logic [1:0]    last;
  logic [CW-1:0] cnt;

  logic [1:0] start;
  logic [7:0] dbl;
  logic [3:0] rot;
  logic [3:0] low;
  logic [1:0] off;
  logic [1:0] pick_idx;
  logic       pick_vld;
  logic       drop;
  logic       hold_done;

  // Rotate so the requester after the last owner sits at bit 0.
  always_comb begin
    start = last + 2'd1;
    dbl   = {i_req, i_req};
    rot   = 4'(dbl >> start);
    low   = rot & (~rot + 4'd1);
    off   = 2'd0;
    unique case (1'b1)
      low[0]:  off = 2'd0;
      low[1]:  off = 2'd1;
      low[2]:  off = 2'd2;
      low[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
    pick_idx = start + off;
    pick_vld = |i_req;
  end

  assign drop      = ~i_req[o_sel];
  assign hold_done = (cnt == CW'(HOLD_MAX));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_gnt     <= 4'd0;
      o_sel     <= 2'd0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      cnt       <= '0;
      last      <= 2'd3;
    end else begin
      unique case (state)
        IDLE: begin
          o_timeout <= 1'b0;
          if (pick_vld) begin
            state   <= GRANT;
            o_gnt   <= 4'b0001 << pick_idx;
            o_sel   <= pick_idx;
            o_valid <= 1'b1;
            cnt     <= CW'(1);
            last    <= pick_idx;
          end
        end
        GRANT: begin
          if (drop || hold_done) begin
            o_timeout <= ~drop;
            if (pick_vld) begin
              o_gnt <= 4'b0001 << pick_idx;
              o_sel <= pick_idx;
              cnt   <= CW'(1);
              last  <= pick_idx;
            end else begin
              state   <= IDLE;
              o_gnt   <= 4'd0;
              o_valid <= 1'b0;
              cnt     <= '0;
            end
          end else begin
            o_timeout <= 1'b0;
            cnt       <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_out = o_valid & i_data[o_sel];

endmodule
